// File: rtl/pll_reconfig_ctrl_pkg.sv
// pll_reconfig_ctrl_pkg: shared state encoding, select width and counter sizing for the rPLL sequencer
package pll_reconfig_ctrl_pkg;
  localparam int SEL_W = 6;
  typedef enum logic [2:0] {HOLD, WAIT_LOCK, STABLE, LOCKED, FAULT} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop single-bit synchronizer, cleared to 0 on reset
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  // shift the async input through two flops
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b00;
    else     {q, m} <= {m, d};
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: loads rPLL divider codes, pulses PLL reset and qualifies a debounced LOCK with timeout
module pll_reconfig_ctrl import pll_reconfig_ctrl_pkg::*; #(
  parameter int               RST_CYCLES   = 16,
  parameter int               LOCK_STABLE  = 256,
  parameter int               LOCK_TIMEOUT = 65535,
  parameter logic [SEL_W-1:0] INIT_IDSEL   = '0,
  parameter logic [SEL_W-1:0] INIT_FBDSEL  = '0,
  parameter logic [SEL_W-1:0] INIT_ODSEL   = '0
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_idsel,
  input  logic [SEL_W-1:0] req_fbdsel,
  input  logic [SEL_W-1:0] req_odsel,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [SEL_W-1:0] pll_idsel,
  output logic [SEL_W-1:0] pll_fbdsel,
  output logic [SEL_W-1:0] pll_odsel,
  output logic             locked,
  output logic             busy,
  output logic             err_timeout
);
  localparam int TW = cnt_w(LOCK_TIMEOUT) > cnt_w(RST_CYCLES) ? cnt_w(LOCK_TIMEOUT) : cnt_w(RST_CYCLES);
  localparam int SW = cnt_w(LOCK_STABLE);
  state_t          state, state_n;
  logic [TW-1:0]   cnt, cnt_n, cnt_inc;
  logic [SW-1:0]   scnt, scnt_n;
  logic            lock_s, acc;
  sync_2ff u_sync (.clk(clkin), .rst(reset), .d(pll_lock), .q(lock_s));
  assign acc     = req_valid && req_ready;
  assign cnt_inc = (cnt < TW'(LOCK_TIMEOUT - 1)) ? cnt + TW'(1) : cnt;
  // next state and counters; the timeout budget keeps running across STABLE dropouts
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    scnt_n  = scnt;
    case (state)
      HOLD: begin
        cnt_n = cnt + TW'(1);
        if (cnt == TW'(RST_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      WAIT_LOCK: begin
        cnt_n = cnt_inc;
        if (lock_s) begin
          state_n = STABLE;
          scnt_n  = SW'(1);
        end else if (cnt == TW'(LOCK_TIMEOUT - 1)) state_n = FAULT;
      end
      STABLE: begin
        cnt_n = cnt_inc;
        if (!lock_s) state_n = WAIT_LOCK;
        else if (scnt == SW'(LOCK_STABLE - 1)) state_n = LOCKED;
        else scnt_n = scnt + SW'(1);
      end
      LOCKED: if (acc || !lock_s) begin
        state_n = HOLD;
        cnt_n   = '0;
      end
      FAULT: if (acc) begin
        state_n = HOLD;
        cnt_n   = '0;
      end
      default: state_n = HOLD;
    endcase
  end
  // state, counters, registered status outputs and selects that only move on an accept
  always_ff @(posedge clkin)
    if (reset) begin
      state       <= HOLD;
      cnt         <= '0;
      scnt        <= '0;
      pll_reset   <= 1'b1;
      locked      <= 1'b0;
      busy        <= 1'b1;
      req_ready   <= 1'b0;
      err_timeout <= 1'b0;
      pll_idsel   <= INIT_IDSEL;
      pll_fbdsel  <= INIT_FBDSEL;
      pll_odsel   <= INIT_ODSEL;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      scnt        <= scnt_n;
      pll_reset   <= state_n inside {HOLD, FAULT};
      locked      <= state_n == LOCKED;
      busy        <= state_n inside {HOLD, WAIT_LOCK, STABLE};
      req_ready   <= state_n inside {LOCKED, FAULT};
      err_timeout <= state_n == FAULT;
      if (acc) begin
        pll_idsel  <= req_idsel;
        pll_fbdsel <= req_fbdsel;
        pll_odsel  <= req_odsel;
      end
    end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: directed checks of power-up, reconfigure, lock glitches, blocked request, timeout and reset
module tb_pll_reconfig_ctrl;
  logic       clkin = 1'b0, reset = 1'b1, req_valid = 1'b0, pll_lock = 1'b0;
  logic [5:0] req_idsel = '0, req_fbdsel = '0, req_odsel = '0;
  logic       req_ready, pll_reset, locked, busy, err_timeout;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  int         cmp = 0, errs = 0, n, mcnt = 0, lock_delay = 100;
  bit         model_en = 1'b1, force_low = 1'b0;

  pll_reconfig_ctrl dut (
    .clkin(clkin), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_idsel(req_idsel), .req_fbdsel(req_fbdsel), .req_odsel(req_odsel),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_idsel(pll_idsel),
    .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .locked(locked),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clkin = ~clkin;

  // PLL model: LOCK rises lock_delay cycles after RESET falls, with an optional forced dropout
  always @(negedge clkin)
    if (pll_reset) begin
      mcnt     = 0;
      pll_lock = 1'b0;
    end else begin
      mcnt++;
      pll_lock = model_en && mcnt > lock_delay && !force_low;
    end

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input int which, input int bound, output int k);
    k = 0;
    while (!(which == 0 ? !pll_reset : which == 1 ? locked : err_timeout) && k < bound) begin
      step();
      k++;
    end
  endtask

  task automatic request(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
    req_idsel  = i;
    req_fbdsel = f;
    req_odsel  = o;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  initial begin
    step(3);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_locked", locked, 0);
    chk("rst_busy", busy, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_sels", {pll_idsel, pll_fbdsel, pll_odsel}, 0);
    reset = 1'b0;
    wait_for(0, 100, n);
    chk("pwr_hold_len", n, 16);
    wait_for(1, 1000, n);
    chk("pwr_lock_time", n, 358);
    chk("pwr_sels", {pll_idsel, pll_fbdsel, pll_odsel}, 0);
    chk("pwr_busy", busy, 0);
    chk("pwr_req_ready", req_ready, 1);

    request(6'd57, 6'd38, 6'd60);
    chk("cfg_sels", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd57, 6'd38, 6'd60});
    chk("cfg_pll_reset", pll_reset, 1);
    chk("cfg_locked", locked, 0);
    chk("cfg_req_ready", req_ready, 0);
    chk("cfg_busy", busy, 1);
    wait_for(0, 100, n);
    chk("cfg_hold_len", n, 16);
    step(150);
    force_low = 1'b1;
    step(3);
    force_low = 1'b0;
    chk("glitch_not_locked", locked, 0);
    wait_for(1, 1000, n);
    chk("glitch_relock_time", n, 258);

    force_low = 1'b1;
    step();
    force_low = 1'b0;
    step();
    chk("drop_still_locked", locked, 1);
    step();
    chk("drop_locked", locked, 0);
    chk("drop_pll_reset", pll_reset, 1);
    chk("drop_sels", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd57, 6'd38, 6'd60});
    wait_for(0, 100, n);
    chk("drop_hold_len", n, 16);

    req_idsel  = 6'd5;
    req_fbdsel = 6'd10;
    req_odsel  = 6'd15;
    req_valid  = 1'b1;
    wait_for(1, 1000, n);
    chk("blk_lock_time", n, 358);
    chk("blk_sels_held", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd57, 6'd38, 6'd60});
    chk("blk_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("blk_sels_new", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd5, 6'd10, 6'd15});
    chk("blk_pll_reset", pll_reset, 1);
    chk("blk_locked", locked, 0);
    wait_for(0, 100, n);
    wait_for(1, 1000, n);
    chk("blk_relock_time", n, 358);

    model_en = 1'b0;
    request(6'd1, 6'd2, 6'd3);
    wait_for(0, 100, n);
    chk("to_hold_len", n, 16);
    wait_for(2, 70000, n);
    chk("to_wait_len", n, 65535);
    chk("to_pll_reset", pll_reset, 1);
    chk("to_busy", busy, 0);
    chk("to_req_ready", req_ready, 1);
    chk("to_locked", locked, 0);
    step(5);
    chk("to_err_sticky", err_timeout, 1);
    model_en = 1'b1;
    request(6'd7, 6'd8, 6'd9);
    chk("rec_err", err_timeout, 0);
    chk("rec_pll_reset", pll_reset, 1);
    chk("rec_busy", busy, 1);
    chk("rec_sels", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd7, 6'd8, 6'd9});

    step(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_sels", {pll_idsel, pll_fbdsel, pll_odsel}, 0);
    chk("mid_rst_pll_reset", pll_reset, 1);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_req_ready", req_ready, 0);
    wait_for(0, 100, n);
    chk("mid_rst_hold_len", n, 16);
    wait_for(1, 1000, n);
    chk("mid_rst_lock_time", n, 358);
    chk("mid_rst_final_sels", {pll_idsel, pll_fbdsel, pll_odsel}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
